axi_refill_responder: RTL and testbench

//   AXI4 slave endpoint for the dcache miss handler's refill and bypass ports. It serves cache-line refill reads,

---
 rtl/axi_refill_responder.sv | 144 ++++++++++++++
 tb/tb_axi_refill_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_refill_responder.sv
// AXI4 slave serving dcache refill reads, write-backs and bypass beats from a word-addressed storage array.
// One burst in flight; registered R channel with 1-cycle storage read; reads take priority over writes in IDLE.
module axi_refill_responder #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS      = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic                        r_last_o,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o
);

  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int OW  = $clog2(BPB);
  localparam int IW  = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WR, WRSP} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q;
  logic [7:0]          len_q;
  logic [7:0]          cnt_q;
  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic ar_fire, aw_fire, r_fire, w_fire;
  logic [IW-1:0] ar_idx, aw_idx, rd_next_idx, wr_idx;
  logic unused_addr_bits;

  // Upper address bits alias onto the array; byte offsets are ignored.
  assign ar_idx = ar_addr_i[OW +: IW];
  assign aw_idx = aw_addr_i[OW +: IW];
  assign unused_addr_bits = ^{ar_addr_i, aw_addr_i};

  assign ar_ready_o = (state_q == IDLE) && !rst_i;
  assign aw_ready_o = (state_q == IDLE) && !rst_i && !ar_valid_i;
  assign w_ready_o  = (state_q == WR);
  assign b_valid_o  = (state_q == WRSP);

  assign ar_fire = ar_ready_o && ar_valid_i;
  assign aw_fire = aw_ready_o && aw_valid_i;
  assign r_fire  = r_valid_o && r_ready_i;
  assign w_fire  = w_ready_o && w_valid_i;

  assign rd_next_idx = idx_q + IW'(cnt_q + 8'd1);
  assign wr_idx      = idx_q + IW'(cnt_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ar_fire)      state_d = RD;
        else if (aw_fire) state_d = WR;
      end
      RD:   if (r_fire && r_last_o) state_d = IDLE;
      WR:   if (w_fire && w_last_i) state_d = WRSP;
      WRSP: if (b_ready_i)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The next beat is fetched on each R handshake so a held-high r_ready_i sees no bubbles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_last_o  <= 1'b0;
      r_id_o    <= '0;
      b_id_o    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_fire) begin
            idx_q     <= ar_idx;
            len_q     <= ar_len_i;
            cnt_q     <= '0;
            r_id_o    <= ar_id_i;
            r_data_o  <= mem[ar_idx];
            r_last_o  <= (ar_len_i == 8'd0);
            r_valid_o <= 1'b1;
          end else if (aw_fire) begin
            idx_q  <= aw_idx;
            len_q  <= aw_len_i;
            cnt_q  <= '0;
            b_id_o <= aw_id_i;
          end
        end
        RD: begin
          if (r_fire) begin
            if (r_last_o) begin
              r_valid_o <= 1'b0;
              r_last_o  <= 1'b0;
            end else begin
              cnt_q    <= cnt_q + 8'd1;
              r_data_o <= mem[rd_next_idx];
              r_last_o <= ((cnt_q + 8'd1) == len_q);
            end
          end
        end
        WR: if (w_fire) cnt_q <= cnt_q + 8'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fire) begin
      for (int b = 0; b < BPB; b++) begin
        if (w_strb_i[b]) mem[wr_idx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_refill_responder.sv
// Self-checking bench: table vectors, directed corner sequences and random bursts against a word-array model.
module tb_axi_refill_responder;

  localparam int MW = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ar_valid_i = 1'b0, ar_ready_o;
  logic [3:0]  ar_id_i = '0;
  logic [63:0] ar_addr_i = '0;
  logic [7:0]  ar_len_i = '0;
  logic        r_valid_o, r_ready_i = 1'b0, r_last_o;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic        aw_valid_i = 1'b0, aw_ready_o;
  logic [3:0]  aw_id_i = '0;
  logic [63:0] aw_addr_i = '0;
  logic [7:0]  aw_len_i = '0;
  logic        w_valid_i = 1'b0, w_ready_o;
  logic [63:0] w_data_i = '0;
  logic [7:0]  w_strb_i = '0;
  logic        w_last_i = 1'b0;
  logic        b_valid_o, b_ready_i = 1'b0;
  logic [3:0]  b_id_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] mem_m [MW];

  axi_refill_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
    .r_data_o(r_data_o), .r_last_o(r_last_o),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic hs_sig(input int sel);
    case (sel)
      0: return ar_ready_o;
      1: return aw_ready_o;
      2: return w_ready_o;
      default: return b_valid_o;
    endcase
  endfunction

  task automatic wait_hs(input int sel, input string nm);
    int n;
    n = 0;
    #1;
    while (!hs_sig(sel) && n < 100) begin
      @(negedge clk_i); #1; n++;
    end
    chk_eq({nm, " handshake"}, 64'(hs_sig(sel)), 64'd1);
  endtask

  function automatic void model_wr(input int idx, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++)
      if (s[b]) mem_m[idx % MW][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic send_ar(input logic [63:0] addr, input int len, input logic [3:0] id);
    ar_valid_i = 1'b1; ar_addr_i = addr; ar_len_i = 8'(len); ar_id_i = id;
    wait_hs(0, "ar");
    @(negedge clk_i);
    ar_valid_i = 1'b0;
  endtask

  // rmode 0: ready held high; 1: random ready. stop_after >= 0 abandons the burst early.
  task automatic collect_r(input logic [63:0] addr, input int len, input logic [3:0] id,
                           input int rmode, input int stop_after);
    int k, n, nb, base;
    bit stalled;
    logic [63:0] pd;
    logic pl;
    k = 0; n = 0; stalled = 0; pd = '0; pl = 1'b0;
    base = int'(addr[12:3]);
    nb = (stop_after >= 0) ? stop_after : len + 1;
    while (k < nb && n < 4000) begin
      r_ready_i = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (r_valid_o) begin
        if (stalled) begin
          chk_eq("r stable data", r_data_o, pd);
          chk_eq("r stable last", 64'(r_last_o), 64'(pl));
        end
        if (r_ready_i) begin
          chk_eq("r data", r_data_o, mem_m[(base + k) % MW]);
          chk_eq("r id", 64'(r_id_o), 64'(id));
          chk_eq("r last", 64'(r_last_o), 64'(k == len));
          k++;
          stalled = 0;
        end else begin
          stalled = 1; pd = r_data_o; pl = r_last_o;
        end
      end
      n++;
      @(negedge clk_i);
    end
    chk_eq("r beat count", 64'(k), 64'(nb));
    if (rmode == 0) chk_eq("r no bubbles", 64'(n), 64'(nb));
    r_ready_i = 1'b0;
    if (stop_after < 0) begin
      #1;
      chk_eq("r valid after last", 64'(r_valid_o), 64'd0);
      chk_eq("ar ready after last", 64'(ar_ready_o), 64'd1);
    end
  endtask

  task automatic send_aw(input logic [63:0] addr, input int len, input logic [3:0] id);
    aw_valid_i = 1'b1; aw_addr_i = addr; aw_len_i = 8'(len); aw_id_i = id;
    wait_hs(1, "aw");
    @(negedge clk_i);
    aw_valid_i = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] addr, input int nbeats, input logic [63:0] dpat,
                        input logic [7:0] strb, input bit rnd);
    int base;
    base = int'(addr[12:3]);
    for (int k = 0; k < nbeats; k++) begin
      w_valid_i = 1'b1;
      w_data_i  = rnd ? {$urandom, $urandom} : dpat + 64'(k);
      w_strb_i  = rnd ? 8'($urandom) : strb;
      w_last_i  = (k == nbeats - 1);
      wait_hs(2, "w");
      model_wr(base + k, w_data_i, w_strb_i);
      @(negedge clk_i);
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
  endtask

  task automatic recv_b(input logic [3:0] id);
    b_ready_i = 1'b1;
    wait_hs(3, "b");
    chk_eq("b id", 64'(b_id_o), 64'(id));
    @(negedge clk_i);
    b_ready_i = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input int len, input logic [3:0] id, input int nbeats,
                          input logic [63:0] dpat, input logic [7:0] strb, input bit rnd);
    send_aw(addr, len, id);
    send_w(addr, nbeats, dpat, strb, rnd);
    recv_b(id);
  endtask

  task automatic do_read(input logic [63:0] addr, input int len, input logic [3:0] id, input int rmode);
    send_ar(addr, len, id);
    collect_r(addr, len, id, rmode, -1);
  endtask

  typedef struct {
    logic [63:0] wa;
    logic [63:0] pre;
    logic [63:0] wd;
    logic [7:0]  st;
    logic [63:0] ra;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{64'h0,    64'hFFFFFFFF_FFFFFFFF, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 64'h0,    64'hFFFFFFFF_BBBBBBBB};
    vt[1] = '{64'h8,    64'h0,                 64'h11223344_55667788, 8'hF0, 64'h8,    64'h11223344_00000000};
    vt[2] = '{64'h2010, 64'h01234567_89ABCDEF, 64'hFFFFFFFF_FFFFFFFF, 8'h81, 64'h10,   64'hFF234567_89ABCDFF};
    vt[3] = '{64'h1FFF, 64'h0,                 64'hDEADBEEF_CAFEF00D, 8'h00, 64'h1FF8, 64'h0};
    vt[4] = '{64'h18,   64'hA5A5A5A5_A5A5A5A5, 64'h5A5A5A5A_5A5A5A5A, 8'h3C, 64'h18,   64'hA5A55A5A_5A5AA5A5};

    // Reset state.
    repeat (2) @(negedge clk_i);
    #1;
    chk_eq("rst ar_ready", 64'(ar_ready_o), 64'd0);
    chk_eq("rst aw_ready", 64'(aw_ready_o), 64'd0);
    chk_eq("rst w_ready",  64'(w_ready_o),  64'd0);
    chk_eq("rst r_valid",  64'(r_valid_o),  64'd0);
    chk_eq("rst b_valid",  64'(b_valid_o),  64'd0);
    chk_eq("rst r_last",   64'(r_last_o),   64'd0);
    chk_eq("rst r_id",     64'(r_id_o),     64'd0);
    chk_eq("rst b_id",     64'(b_id_o),     64'd0);
    chk_eq("rst r_data",   r_data_o,        64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Fill the whole array with 256-beat bursts, then read one back with ready held high.
    for (int i = 0; i < 4; i++) do_write(64'(i * 2048), 255, 4'(i), 256, '0, 8'hFF, 1'b1);
    do_read(64'h800, 255, 4'h9, 0);

    // Refill write-back then read.
    do_write(64'h80, 7, 4'd3, 8, 64'h1000, 8'hFF, 1'b0);
    do_read(64'h80, 7, 4'd5, 0);

    // Strobe / aliasing vectors.
    foreach (vt[i]) begin
      do_write(vt[i].wa, 0, 4'd1, 1, vt[i].pre, 8'hFF, 1'b0);
      do_write(vt[i].wa, 0, 4'd2, 1, vt[i].wd, vt[i].st, 1'b0);
      send_ar(vt[i].ra, 0, 4'd4);
      r_ready_i = 1'b1;
      #1;
      chk_eq("vec data", r_data_o, vt[i].exp);
      chk_eq("vec last", 64'(r_last_o), 64'd1);
      @(negedge clk_i);
      r_ready_i = 1'b0;
    end

    // Stalled 16-beat read; wrap at the top of the array.
    do_read(64'h340, 15, 4'hA, 1);
    do_read(64'h1FF8, 1, 4'hB, 0);

    // Simultaneous AR and AW: read first, AW accepted right after the last R beat.
    aw_valid_i = 1'b1; aw_addr_i = 64'h300; aw_len_i = 8'd0; aw_id_i = 4'd6;
    ar_valid_i = 1'b1; ar_addr_i = 64'h200; ar_len_i = 8'd3; ar_id_i = 4'd7;
    #1;
    chk_eq("race ar_ready", 64'(ar_ready_o), 64'd1);
    chk_eq("race aw_ready", 64'(aw_ready_o), 64'd0);
    @(negedge clk_i);
    ar_valid_i = 1'b0;
    collect_r(64'h200, 3, 4'd7, 0, -1);
    chk_eq("race aw_ready after read", 64'(aw_ready_o), 64'd1);
    @(negedge clk_i);
    aw_valid_i = 1'b0;
    send_w(64'h300, 1, 64'h5555_0000_1234_9999, 8'hFF, 1'b0);
    recv_b(4'd6);
    do_read(64'h300, 0, 4'd1, 0);

    // Early and late w_last.
    do_write(64'h500, 7, 4'hC, 3, 64'h7700, 8'hFF, 1'b0);
    do_write(64'h600, 1, 4'hD, 4, 64'h8800, 8'hFF, 1'b0);
    do_read(64'h500, 7, 4'hC, 0);
    do_read(64'h600, 3, 4'hD, 1);

    // Reset after 2 of 8 read beats.
    send_ar(64'h400, 7, 4'd8);
    collect_r(64'h400, 7, 4'd8, 0, 2);
    rst_i = 1'b1;
    #1;
    chk_eq("midrst r_valid", 64'(r_valid_o), 64'd0);
    chk_eq("midrst ar_ready", 64'(ar_ready_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk_eq("postrst r_valid", 64'(r_valid_o), 64'd0);
    chk_eq("postrst ar_ready", 64'(ar_ready_o), 64'd1);
    @(negedge clk_i);
    do_read(64'h400, 7, 4'd9, 1);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      logic [63:0] a;
      int len, nb;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        len = $urandom_range(0, 15);
        case ($urandom_range(0, 5))
          0: nb = (len > 1) ? len - 1 : 1;
          1: nb = len + 3;
          default: nb = len + 1;
        endcase
        do_write(a, len, 4'($urandom), nb, '0, 8'h00, 1'b1);
      end else begin
        do_read(a, $urandom_range(0, 31), 4'($urandom), int'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
